// File: rtl/pc_pkg.sv
// Shared constants and types for the program-counter unit.
// Holds the instruction size and the next-PC source select enum.
package pc_pkg;

    localparam int ILEN_BYTES = 4;

    typedef enum logic [2:0] {
        SEL_TRAP,
        SEL_REDIRECT,
        SEL_HOLD,
        SEL_RAS,
        SEL_SEQ
    } pc_sel_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack; a push on a full stack overwrites the oldest entry.
// Ports: clk, reset_n, push/pop/push_data in, top/empty/full out.
module pc_ras #(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_data,
    output logic [XLEN-1:0] top,
    output logic            empty,
    output logic            full
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW+1)'(RAS_DEPTH);

    logic [XLEN-1:0] mem_q [RAS_DEPTH];
    logic [XLEN-1:0] mem_d [RAS_DEPTH];
    logic [PW-1:0]   sp_q, sp_d;
    logic [PW:0]     cnt_q, cnt_d;
    logic [PW-1:0]   top_idx;
    logic            pop_ok;

    // sp points at the next free slot; the top lives one below it.
    assign top_idx = sp_q - 1'b1;
    assign top     = mem_q[top_idx];
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == DEPTH_C);
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d = mem_q;
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (push && pop_ok) begin
            // Pop then push collapses to replacing the top in place.
            mem_d[top_idx] = push_data;
        end else if (push) begin
            mem_d[sp_q] = push_data;
            sp_d        = sp_q + 1'b1;
            if (!full) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop_ok) begin
            sp_d  = sp_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RAS_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with trap/redirect/stall priority and optional return-address stack.
// Ports: clk, reset_n, stall, redirect_valid/pc, trap_valid/vector, call, ret in;
// current_pc, misaligned, ras_empty, ras_full out. RAS built when PC_UNIT_RAS_EN is defined.
module pc_unit
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            call,
    input  logic            ret,
    output logic [XLEN-1:0] current_pc,
    output logic            misaligned,
    output logic            ras_empty,
    output logic            ras_full
);

    logic [XLEN-1:0] current_pc_q, current_pc_d;
    logic            misaligned_q, misaligned_d;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] ras_top;
    logic            ras_push;
    logic            ras_pop;
    pc_sel_e         sel;

    assign seq_pc     = current_pc_q + XLEN'(ILEN_BYTES);
    assign current_pc = current_pc_q;
    assign misaligned = misaligned_q;

    always_comb begin
        sel = SEL_SEQ;
        if (trap_valid) begin
            sel = SEL_TRAP;
        end else if (redirect_valid) begin
            sel = SEL_REDIRECT;
        end else if (stall) begin
            sel = SEL_HOLD;
        end else if (ret && !ras_empty) begin
            sel = SEL_RAS;
        end
    end

    // Stack ops only happen on cycles that fetch down the predicted path.
    assign ras_pop  = (sel == SEL_RAS);
    assign ras_push = call && ((sel == SEL_RAS) || (sel == SEL_SEQ));

    always_comb begin
        current_pc_d = seq_pc;
        misaligned_d = 1'b0;
        unique case (sel)
            SEL_TRAP:     current_pc_d = {trap_vector[XLEN-1:2], 2'b00};
            SEL_REDIRECT: begin
                current_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
                misaligned_d = |redirect_pc[1:0];
            end
            SEL_HOLD:     current_pc_d = current_pc_q;
            SEL_RAS:      current_pc_d = ras_top;
            SEL_SEQ:      current_pc_d = seq_pc;
            default:      current_pc_d = seq_pc;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            current_pc_q <= RESET_VECTOR;
            misaligned_q <= 1'b0;
        end else begin
            current_pc_q <= current_pc_d;
            misaligned_q <= misaligned_d;
        end
    end

`ifdef PC_UNIT_RAS_EN
    pc_ras #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (seq_pc),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );
`else
    logic unused_ras;
    assign unused_ras = ras_push ^ ras_pop;
    assign ras_top    = '0;
    assign ras_empty  = 1'b1;
    assign ras_full   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: expected PCs are queued as stimulus is driven
// and compared after each rising edge. RAS scenarios depend on PC_UNIT_RAS_EN.
module tb_pc_unit;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        trap_valid;
    logic [31:0] trap_vector;
    logic        call;
    logic        ret;
    logic [31:0] current_pc;
    logic        misaligned;
    logic        ras_empty;
    logic        ras_full;

    int          vectors;
    int          miscompares;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    pc_unit #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0),
        .RAS_DEPTH    (4)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_vector    (trap_vector),
        .call           (call),
        .ret            (ret),
        .current_pc     (current_pc),
        .misaligned     (misaligned),
        .ras_empty      (ras_empty),
        .ras_full       (ras_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        stall = 0; redirect_valid = 0; redirect_pc = '0;
        trap_valid = 0; trap_vector = '0; call = 0; ret = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (current_pc !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want %h", current_pc, 32'h0); end
        vectors++; if (misaligned !== 1'b0) begin miscompares++; $display("FAIL reset_mis: got %b want 0", misaligned); end
        vectors++; if (ras_empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b want 1", ras_empty); end
        vectors++; if (ras_full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %b want 0", ras_full); end
        reset_n = 1;
        #1;
        vectors++; if (current_pc !== 32'h0) begin miscompares++; $display("FAIL release_pc: got %h want %h", current_pc, 32'h0); end
        exp_q.push_back(32'h4);
        exp_q.push_back(32'h8);
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_pc = exp_q.pop_front();
            vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL seq_after_reset: got %h want %h", current_pc, exp_pc); end
        end
    endtask

    task automatic test_redirect();
        redirect_valid = 1; redirect_pc = 32'h000000A2;
        exp_q.push_back(32'hA0);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL redirect_pc: got %h want %h", current_pc, exp_pc); end
        vectors++; if (misaligned !== 1'b1) begin miscompares++; $display("FAIL redirect_mis_hi: got %b want 1", misaligned); end
        idle();
        exp_q.push_back(32'hA4);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL redirect_seq: got %h want %h", current_pc, exp_pc); end
        vectors++; if (misaligned !== 1'b0) begin miscompares++; $display("FAIL redirect_mis_lo: got %b want 0", misaligned); end
    endtask

    task automatic test_trap();
        trap_valid = 1; trap_vector = 32'h100;
        stall = 1; redirect_valid = 1; redirect_pc = 32'h203;
        exp_q.push_back(32'h100);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL trap_pc: got %h want %h", current_pc, exp_pc); end
        vectors++; if (misaligned !== 1'b0) begin miscompares++; $display("FAIL trap_mis: got %b want 0", misaligned); end
        idle();
        trap_valid = 1; trap_vector = 32'h207;
        exp_q.push_back(32'h204);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL trap_align: got %h want %h", current_pc, exp_pc); end
        idle();
        stall = 1;
        exp_q.push_back(32'h204);
        exp_q.push_back(32'h204);
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_pc = exp_q.pop_front();
            vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL stall_hold: got %h want %h", current_pc, exp_pc); end
        end
        idle();
    endtask

`ifdef PC_UNIT_RAS_EN
    task automatic test_ras_lifo();
        redirect_valid = 1; redirect_pc = 32'h10;
        exp_q.push_back(32'h10);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL ras_setup: got %h want %h", current_pc, exp_pc); end
        idle(); call = 1;
        exp_q.push_back(32'h14);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL call1_pc: got %h want %h", current_pc, exp_pc); end
        vectors++; if (ras_empty !== 1'b0) begin miscompares++; $display("FAIL call1_empty: got %b want 0", ras_empty); end
        idle(); redirect_valid = 1; redirect_pc = 32'h40;
        exp_q.push_back(32'h40);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL call_jump: got %h want %h", current_pc, exp_pc); end
        idle(); call = 1;
        exp_q.push_back(32'h44);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL call2_pc: got %h want %h", current_pc, exp_pc); end
        idle(); ret = 1;
        exp_q.push_back(32'h44);
        exp_q.push_back(32'h14);
        exp_q.push_back(32'h18);
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_pc = exp_q.pop_front();
            vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL ret_pc[%0d]: got %h want %h", i, current_pc, exp_pc); end
        end
        vectors++; if (ras_empty !== 1'b1) begin miscompares++; $display("FAIL ret_empty: got %b want 1", ras_empty); end
        idle();
    endtask

    task automatic test_ras_full();
        redirect_valid = 1; redirect_pc = 32'h1000;
        exp_q.push_back(32'h1000);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL full_setup: got %h want %h", current_pc, exp_pc); end
        idle(); call = 1;
        for (int i = 1; i <= 5; i++) begin
            exp_q.push_back(32'h1000 + 32'(4 * i));
            tick();
            exp_pc = exp_q.pop_front();
            vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL full_call[%0d]: got %h want %h", i, current_pc, exp_pc); end
        end
        vectors++; if (ras_full !== 1'b1) begin miscompares++; $display("FAIL full_flag: got %b want 1", ras_full); end
        idle(); call = 1; redirect_valid = 1; redirect_pc = 32'h2000;
        exp_q.push_back(32'h2000);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL full_redirect: got %h want %h", current_pc, exp_pc); end
        vectors++; if (ras_full !== 1'b1) begin miscompares++; $display("FAIL full_kept: got %b want 1", ras_full); end
        idle(); ret = 1;
        exp_q.push_back(32'h1014);
        exp_q.push_back(32'h1010);
        exp_q.push_back(32'h100C);
        exp_q.push_back(32'h1008);
        exp_q.push_back(32'h100C);
        for (int i = 0; i < 5; i++) begin
            tick();
            exp_pc = exp_q.pop_front();
            vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL full_ret[%0d]: got %h want %h", i, current_pc, exp_pc); end
        end
        vectors++; if (ras_empty !== 1'b1) begin miscompares++; $display("FAIL full_drained: got %b want 1", ras_empty); end
        idle();
    endtask

    task automatic test_back_to_back();
        redirect_valid = 1; redirect_pc = 32'h3000;
        exp_q.push_back(32'h3000);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL b2b_setup: got %h want %h", current_pc, exp_pc); end
        idle(); call = 1;
        exp_q.push_back(32'h3004);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL b2b_call: got %h want %h", current_pc, exp_pc); end
        call = 1; ret = 1;
        exp_q.push_back(32'h3004);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL b2b_callret: got %h want %h", current_pc, exp_pc); end
        vectors++; if (ras_empty !== 1'b0) begin miscompares++; $display("FAIL b2b_count: got %b want 0", ras_empty); end
        idle(); stall = 1; call = 1; ret = 1;
        exp_q.push_back(32'h3004);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL b2b_stall: got %h want %h", current_pc, exp_pc); end
        idle(); ret = 1;
        exp_q.push_back(32'h3008);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL b2b_ret: got %h want %h", current_pc, exp_pc); end
        vectors++; if (ras_empty !== 1'b1) begin miscompares++; $display("FAIL b2b_empty: got %b want 1", ras_empty); end
        idle();
    endtask
`else
    task automatic test_no_ras();
        redirect_valid = 1; redirect_pc = 32'h10;
        exp_q.push_back(32'h10);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL noras_setup: got %h want %h", current_pc, exp_pc); end
        idle(); call = 1;
        exp_q.push_back(32'h14);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL noras_call: got %h want %h", current_pc, exp_pc); end
        idle(); ret = 1;
        exp_q.push_back(32'h18);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL noras_ret: got %h want %h", current_pc, exp_pc); end
        vectors++; if (ras_empty !== 1'b1) begin miscompares++; $display("FAIL noras_empty: got %b want 1", ras_empty); end
        vectors++; if (ras_full !== 1'b0) begin miscompares++; $display("FAIL noras_full: got %b want 0", ras_full); end
        idle();
    endtask
`endif

    task automatic test_wrap();
        redirect_valid = 1; redirect_pc = 32'hFFFFFFFC;
        exp_q.push_back(32'hFFFFFFFC);
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h4);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL wrap_setup: got %h want %h", current_pc, exp_pc); end
        idle();
        for (int i = 0; i < 2; i++) begin
            tick();
            exp_pc = exp_q.pop_front();
            vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL wrap_seq[%0d]: got %h want %h", i, current_pc, exp_pc); end
        end
    endtask

    task automatic test_async_reset();
        redirect_valid = 1; redirect_pc = 32'h501;
        exp_q.push_back(32'h500);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL ar_setup: got %h want %h", current_pc, exp_pc); end
        idle(); call = 1;
        exp_q.push_back(32'h504);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL ar_call: got %h want %h", current_pc, exp_pc); end
        idle(); stall = 1; redirect_valid = 1; redirect_pc = 32'h603;
        exp_q.push_back(32'h600);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL ar_redirect: got %h want %h", current_pc, exp_pc); end
        vectors++; if (misaligned !== 1'b1) begin miscompares++; $display("FAIL ar_mis_pre: got %b want 1", misaligned); end
        #2;
        reset_n = 0;
        #1;
        vectors++; if (current_pc !== 32'h0) begin miscompares++; $display("FAIL ar_pc: got %h want %h", current_pc, 32'h0); end
        vectors++; if (misaligned !== 1'b0) begin miscompares++; $display("FAIL ar_mis: got %b want 0", misaligned); end
        vectors++; if (ras_empty !== 1'b1) begin miscompares++; $display("FAIL ar_empty: got %b want 1", ras_empty); end
        idle();
        tick();
        reset_n = 1;
        exp_q.push_back(32'h4);
        tick();
        exp_pc = exp_q.pop_front();
        vectors++; if (current_pc !== exp_pc) begin miscompares++; $display("FAIL ar_release: got %h want %h", current_pc, exp_pc); end
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        test_reset();
        test_redirect();
        test_trap();
`ifdef PC_UNIT_RAS_EN
        test_ras_lifo();
        test_ras_full();
        test_back_to_back();
`else
        test_no_ras();
`endif
        test_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter XLEN, default 32, width of PC and all address ports.
REQ-002 Parameter RESET_VECTOR, default 32'h00000000, PC value after reset.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries; SHALL be a power of two and at least 2.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 stall  input  1  hold PC and RAS this cycle.
REQ-007 redirect_valid  input  1  branch/jump resolved; load redirect_pc.
REQ-008 redirect_pc  input  XLEN  redirect target.
REQ-009 trap_valid  input  1  exception; load trap_vector.
REQ-010 trap_vector  input  XLEN  trap handler address.
REQ-011 call  input  1  the instruction at current_pc is a call; push current_pc+4.
REQ-012 ret  input  1  the instruction at current_pc is a return; predict the next PC from the RAS top.
REQ-013 current_pc  output  XLEN  registered program counter.
REQ-014 misaligned  output  1  registered one-cycle pulse; the last redirect target had bits [1:0] != 0.
REQ-015 ras_empty  output  1  RAS holds no entries.
REQ-016 ras_full  output  1  RAS holds RAS_DEPTH entries.

Function
REQ-017 current_pc SHALL update only on the rising edge of clk, with one-cycle latency from the inputs.
REQ-018 Next-PC priority SHALL be, highest first: trap_valid, redirect_valid, stall, ret with RAS non-empty, sequential.
REQ-019 Trap: next PC = trap_vector with bits [1:0] cleared; this SHALL override stall.
REQ-020 Redirect: next PC = redirect_pc with bits [1:0] cleared; misaligned = (redirect_pc[1:0] != 0) on the following cycle, and 0 otherwise.
REQ-021 Stall without trap or redirect: current_pc holds, and the RAS is unchanged.
REQ-022 Sequential: next PC = current_pc + 4 modulo 2^XLEN; at 0xFFFFFFFC it SHALL wrap to 0x00000000.
REQ-023 Ret with RAS non-empty: next PC = top entry, and the entry is popped.
REQ-024 Ret with RAS empty: next PC is sequential, and no pop occurs.
REQ-025 Call pushes current_pc+4.
REQ-026 Call with RAS full: the oldest entry is overwritten (circular buffer); the count stays RAS_DEPTH and ras_full stays 1.
REQ-027 Call and ret in the same cycle: the top entry is popped as the predicted PC, then replaced by current_pc+4; the count is unchanged.
REQ-028 Call and ret SHALL be ignored (no push, no pop) in any cycle with trap_valid, redirect_valid or stall asserted.
REQ-029 Trap and redirect SHALL NOT flush the RAS.

Reset
REQ-030 While reset_n = 0: current_pc = RESET_VECTOR, misaligned = 0, RAS count = 0, ras_empty = 1, ras_full = 0.
REQ-031 Reset SHALL take effect immediately and asynchronously, including mid-stall or mid-redirect.
REQ-032 Reset SHALL be released synchronously; the first increment happens on the first rising edge with reset_n = 1.

Configuration
REQ-033 Macro PC_UNIT_RAS_EN defined: the RAS is built and behaves per REQ-023 to REQ-029.
REQ-034 Macro PC_UNIT_RAS_EN undefined: no RAS storage; call and ret are ignored; ras_empty is tied to 1 and ras_full to 0; ret always takes the sequential path.

Structure
REQ-035 Package pc_pkg SHALL hold the ILEN_BYTES = 4 constant and the next-PC select enum (SEL_TRAP, SEL_REDIRECT, SEL_HOLD, SEL_RAS, SEL_SEQ).
REQ-036 The RAS SHALL be the sub-module pc_ras (parameters XLEN and RAS_DEPTH; ports push, pop, push_data, top, empty, full), instantiated only under PC_UNIT_RAS_EN.

Verification
REQ-037 Hold reset_n = 0 for 2 cycles, then release with no other inputs -> current_pc = 0x0, then 0x4, then 0x8 on successive edges.
REQ-038 Redirect to 0x000000A2 -> current_pc = 0x000000A0 next cycle, misaligned pulses high for exactly 1 cycle.
REQ-039 Trap to 0x100 with stall and redirect also asserted -> current_pc = 0x100.
REQ-040 Call at 0x10, call at 0x40, then ret twice -> next PCs are 0x44 then 0x14; ras_empty = 1 afterwards; a further ret gives the sequential PC.
REQ-041 Five calls with RAS_DEPTH = 4 -> ras_full = 1; four rets return the last four pushes in LIFO order.
REQ-042 current_pc = 0xFFFFFFFC with no control inputs -> 0x00000000; reset_n pulsed low mid-stall -> current_pc = RESET_VECTOR immediately, before the next edge.
